axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
Two-requester AXI4-Lite read-channel arbiter that shares one memory-side read port between the instruction cache (port s0) and the data-side read path (port s1). Only one read transaction is in flight at a time. The arbiter latches the winning request, drives it to memory, and routes the single read beat back to the winner only. It sits between the cache AXI masters and the memory/interconnect read slave.

Parameters:
ADDR_WIDTH, 32, width of all araddr buses.
FIXED_PRIO, 0, 0 = round-robin between s0 and s1; 1 = s1 always wins when both request.

Ports:
clk  input  1  single clock, all logic on posedge.
reset  input  1  asynchronous, active-low reset.
s0_arvalid  input  1  requester 0 (icache) read-address valid.
s0_arready  output  1  requester 0 address accepted.
s0_araddr  input  ADDR_WIDTH  requester 0 address.
s0_arprot  input  3  requester 0 protection.
s0_rvalid  output  1  read data valid to requester 0.
s0_rready  input  1  requester 0 ready for data.
s0_rdata  output  32  read data to requester 0.
s0_rresp  output  2  read response to requester 0.
s1_arvalid, s1_arready, s1_araddr, s1_arprot, s1_rvalid, s1_rready, s1_rdata, s1_rresp: same as s0, for requester 1.
m_arvalid  output  1  memory read-address valid.
m_arready  input  1  memory address accepted.
m_araddr  output  ADDR_WIDTH  memory address.
m_arprot  output  3  memory protection.
m_rvalid  input  1  memory read data valid.
m_rready  output  1  arbiter ready for memory data.
m_rdata  input  32  memory read data.
m_rresp  input  2  memory read response.
busy  output  1  high when state != IDLE.
grant  output  1  index of the current/last winner.

Behaviour:
- States: IDLE, ADDR, DATA, encoded in 2 bits.
- Reset (reset=0, asynchronous): state=IDLE; m_arvalid=0; m_araddr=0; m_arprot=0; grant=0; last_grant=1, so s0 wins the first tie; busy=0.
- Reset asserted mid-transaction abandons the transaction. There is no replay. The memory side must also be reset.
- IDLE:
  - sel is combinational: only one arvalid high -> that requester. Both high -> FIXED_PRIO=1 selects s1; otherwise select the requester other than last_grant. Neither high -> no action.
  - sN_arready = (state==IDLE) & sN_arvalid & (sel==N). Asserted in the same cycle as the request; at most one sN_arready is high.
  - On acceptance at the posedge: latch araddr/arprot into m_araddr/m_arprot; grant<=sel; m_arvalid<=1; go to ADDR.
- ADDR:
  - m_arvalid held at 1 with a stable address until m_arready=1.
  - At that edge: m_arvalid<=0; go to DATA.
- DATA:
  - m_rready = s[grant]_rready, combinational.
  - s[grant]_rvalid = m_rvalid, combinational. The other requester's rvalid=0.
  - rdata/rresp are routed to the winner. The loser's rdata/rresp are driven to 0.
  - On m_rvalid & m_rready: last_grant<=grant; go to IDLE.
- All sN_arready=0 outside IDLE. A requester that keeps arvalid high waits; its request is not lost.
- The minimum transaction is 3 cycles: accept (IDLE) -> ADDR (m_arready same cycle) -> DATA (m_rvalid & rready same cycle). A new accept is possible on the cycle after DATA completes.
- m_rvalid in IDLE/ADDR is ignored: m_rready=0 and no requester sees it.
- A requester that drops arvalid in IDLE before acceptance is not granted.
- rresp is passed through unmodified. SLVERR/DECERR carry no special handling.
- Round-robin updates last_grant only on transaction completion.

Test Plan:
1. Reset, then single s0 read at 0x0000_0100; memory asserts arready after 2 cycles and returns rdata=0xDEAD_BEEF, rresp=0 -> s0_arready pulses once; m_araddr=0x100; s0 receives 0xDEAD_BEEF; s1_rvalid stays 0; busy falls after completion.
2. s0 and s1 request simultaneously (0x100, 0x200), FIXED_PRIO=0, both held -> grants alternate s0 (first after reset), s1, s0; m_araddr sequence 0x100, 0x200, 0x100.
3. Same as 2 with FIXED_PRIO=1 and s1 held continuously -> s1 is granted every time; s0 is granted only once s1 drops arvalid.
4. Back-to-back: memory has zero-wait arready and rvalid, and the requester holds rready=1 -> each transaction takes exactly 3 cycles; the next accept occurs on the cycle after the data beat.
5. Requester delays rready by 4 cycles while m_rvalid=1 with data 0x1234_5678 -> m_rready stays 0 until s_rready=1; data is delivered intact; the state stays DATA until then.
6. Assert reset in the DATA state, then deassert -> all outputs return to reset values immediately (asynchronously); the next s1 request is accepted normally; rresp=2'b10 injected on it is passed to s1 unchanged.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI4-Lite read port between two requesters, one transaction at a time
module axi_read_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  s0_arvalid,
   output logic                  s0_arready,
   input  logic [ADDR_WIDTH-1:0] s0_araddr,
   input  logic [2:0]            s0_arprot,
   output logic                  s0_rvalid,
   input  logic                  s0_rready,
   output logic [31:0]           s0_rdata,
   output logic [1:0]            s0_rresp,
   input  logic                  s1_arvalid,
   output logic                  s1_arready,
   input  logic [ADDR_WIDTH-1:0] s1_araddr,
   input  logic [2:0]            s1_arprot,
   output logic                  s1_rvalid,
   input  logic                  s1_rready,
   output logic [31:0]           s1_rdata,
   output logic [1:0]            s1_rresp,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [2:0]            m_arprot,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   input  logic [31:0]           m_rdata,
   input  logic [1:0]            m_rresp,
   output logic                  busy,
   output logic                  grant
);
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
   state_t                state_q, state_d;
   logic                  m_arvalid_q, m_arvalid_d;
   logic [ADDR_WIDTH-1:0] m_araddr_q, m_araddr_d;
   logic [2:0]            m_arprot_q, m_arprot_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic                  sel, in_idle, in_data, win_rready;
   // winner selection: a tie goes to s1 under fixed priority, else away from the last winner
   always_comb begin
      sel        = (s0_arvalid & s1_arvalid) ? (FIXED_PRIO ? 1'b1 : ~last_grant_q) : s1_arvalid;
      in_idle    = state_q == IDLE;
      in_data    = state_q == DATA;
      win_rready = grant_q ? s1_rready : s0_rready;
   end
   // state and latched request registers; last_grant starts at 1 so s0 wins the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         m_arvalid_q  <= 1'b0;
         m_araddr_q   <= '0;
         m_arprot_q   <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         m_arvalid_q  <= m_arvalid_d;
         m_araddr_q   <= m_araddr_d;
         m_arprot_q   <= m_arprot_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end
   // next state: accept in IDLE, hand the address over in ADDR, wait for the beat in DATA
   always_comb begin
      state_d      = state_q;
      m_arvalid_d  = m_arvalid_q;
      m_araddr_d   = m_araddr_q;
      m_arprot_d   = m_arprot_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      if (in_idle && (s0_arvalid || s1_arvalid)) begin
         state_d     = ADDR;
         m_arvalid_d = 1'b1;
         m_araddr_d  = sel ? s1_araddr : s0_araddr;
         m_arprot_d  = sel ? s1_arprot : s0_arprot;
         grant_d     = sel;
      end else if (state_q == ADDR && m_arready) begin
         state_d     = DATA;
         m_arvalid_d = 1'b0;
      end else if (in_data && m_rvalid && win_rready) begin
         state_d      = IDLE;
         last_grant_d = grant_q;
      end
   end
   // outputs: handshakes only in IDLE, read beat routed to the winner only during DATA
   always_comb begin
      s0_arready = in_idle & s0_arvalid & ~sel;
      s1_arready = in_idle & s1_arvalid & sel;
      m_rready   = in_data & win_rready;
      s0_rvalid  = in_data & ~grant_q & m_rvalid;
      s1_rvalid  = in_data & grant_q & m_rvalid;
      s0_rdata   = (in_data & ~grant_q) ? m_rdata : '0;
      s1_rdata   = (in_data & grant_q) ? m_rdata : '0;
      s0_rresp   = (in_data & ~grant_q) ? m_rresp : '0;
      s1_rresp   = (in_data & grant_q) ? m_rresp : '0;
      m_arvalid  = m_arvalid_q;
      m_araddr   = m_araddr_q;
      m_arprot   = m_arprot_q;
      busy       = ~in_idle;
      grant      = grant_q;
   end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: round-robin and fixed-priority arbiters driven side by side, checked against a transaction model
module tb_axi_read_arbiter;
   logic clk = 1'b0, reset = 1'b0;
   logic s0_arvalid = 0, s1_arvalid = 0, s0_rready = 0, s1_rready = 0;
   logic [31:0] s0_araddr = 0, s1_araddr = 0, m_rdata = 0;
   logic [2:0] s0_arprot = 0, s1_arprot = 0;
   logic m_arready = 0, m_rvalid = 0;
   logic [1:0] m_rresp = 0;
   logic s0_arready[2], s1_arready[2], s0_rvalid[2], s1_rvalid[2];
   logic [31:0] s0_rdata[2], s1_rdata[2], m_araddr[2];
   logic [1:0] s0_rresp[2], s1_rresp[2];
   logic [2:0] m_arprot[2];
   logic m_arvalid[2], m_rready[2], busy[2], grant[2];
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   // instance 0 is round-robin, instance 1 is fixed priority; both see identical stimulus
   for (genvar g = 0; g < 2; g++) begin : g_dut
      axi_read_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(g == 1)) u_dut (
         .clk(clk), .reset(reset),
         .s0_arvalid(s0_arvalid), .s0_arready(s0_arready[g]), .s0_araddr(s0_araddr), .s0_arprot(s0_arprot),
         .s0_rvalid(s0_rvalid[g]), .s0_rready(s0_rready), .s0_rdata(s0_rdata[g]), .s0_rresp(s0_rresp[g]),
         .s1_arvalid(s1_arvalid), .s1_arready(s1_arready[g]), .s1_araddr(s1_araddr), .s1_arprot(s1_arprot),
         .s1_rvalid(s1_rvalid[g]), .s1_rready(s1_rready), .s1_rdata(s1_rdata[g]), .s1_rresp(s1_rresp[g]),
         .m_arvalid(m_arvalid[g]), .m_arready(m_arready), .m_araddr(m_araddr[g]), .m_arprot(m_arprot[g]),
         .m_rvalid(m_rvalid), .m_rready(m_rready[g]), .m_rdata(m_rdata), .m_rresp(m_rresp),
         .busy(busy[g]), .grant(grant[g]));
   end

   task automatic chk(input int i, input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s[inst %0d]: got %h expected %h", n, i, a, e);
      end
   endtask

   // transaction model: is a read open, has its address been handed over, who owns it, who won last
   bit open_m[2], sent_m[2], owner_m[2], last_m[2];
   logic [31:0] addr_m[2];
   logic [2:0] prot_m[2];
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            open_m[i] = 0; sent_m[i] = 0; owner_m[i] = 0; last_m[i] = 1; addr_m[i] = 0; prot_m[i] = 0;
         end else begin
            bit pick, dat, rr;
            pick = (s0_arvalid && s1_arvalid) ? (i == 1 ? 1'b1 : !last_m[i]) : s1_arvalid;
            dat = open_m[i] && sent_m[i];
            rr = owner_m[i] ? s1_rready : s0_rready;
            chk(i, "s0_arready", s0_arready[i], !open_m[i] && s0_arvalid && !pick);
            chk(i, "s1_arready", s1_arready[i], !open_m[i] && s1_arvalid && pick);
            chk(i, "m_arvalid", m_arvalid[i], open_m[i] && !sent_m[i]);
            chk(i, "m_araddr", m_araddr[i], addr_m[i]);
            chk(i, "m_arprot", m_arprot[i], prot_m[i]);
            chk(i, "m_rready", m_rready[i], dat && rr);
            chk(i, "s0_rvalid", s0_rvalid[i], dat && !owner_m[i] && m_rvalid);
            chk(i, "s1_rvalid", s1_rvalid[i], dat && owner_m[i] && m_rvalid);
            chk(i, "s0_rdata", s0_rdata[i], (dat && !owner_m[i]) ? m_rdata : 0);
            chk(i, "s1_rdata", s1_rdata[i], (dat && owner_m[i]) ? m_rdata : 0);
            chk(i, "s0_rresp", s0_rresp[i], (dat && !owner_m[i]) ? m_rresp : 0);
            chk(i, "s1_rresp", s1_rresp[i], (dat && owner_m[i]) ? m_rresp : 0);
            chk(i, "busy", busy[i], open_m[i]);
            chk(i, "grant", grant[i], owner_m[i]);
            if (!open_m[i] && (s0_arvalid || s1_arvalid)) begin
               open_m[i] = 1; sent_m[i] = 0; owner_m[i] = pick;
               addr_m[i] = pick ? s1_araddr : s0_araddr;
               prot_m[i] = pick ? s1_arprot : s0_arprot;
            end else if (open_m[i] && !sent_m[i] && m_arready) sent_m[i] = 1;
            else if (dat && m_rvalid && rr) begin
               open_m[i] = 0; last_m[i] = owner_m[i];
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 0;
      repeat (2) cyc();
      reset = 1;
   endtask

   initial begin
      do_reset();
      // single s0 read, memory address-ready after two wait cycles
      s0_arvalid = 1; s0_araddr = 32'h100; s0_arprot = 3'd2;
      @(negedge clk);
      chk(0, "t1_arready", s0_arready[0], 1);
      chk(0, "t1_busy_idle", busy[0], 0);
      cyc(); s0_arvalid = 0;
      @(negedge clk);
      chk(0, "t1_m_arvalid", m_arvalid[0], 1);
      chk(0, "t1_m_araddr", m_araddr[0], 32'h100);
      chk(0, "t1_arready_low", s0_arready[0], 0);
      cyc(); cyc(); m_arready = 1;
      cyc(); m_arready = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 0; s0_rready = 1;
      @(negedge clk);
      chk(0, "t1_s0_rvalid", s0_rvalid[0], 1);
      chk(0, "t1_s0_rdata", s0_rdata[0], 32'hDEADBEEF);
      chk(0, "t1_s1_rvalid", s1_rvalid[0], 0);
      cyc(); m_rvalid = 0;
      @(negedge clk);
      chk(0, "t1_busy_done", busy[0], 0);
      // ties with zero-wait memory: 3-cycle transactions, RR alternates, fixed priority sticks to s1
      do_reset();
      s0_arvalid = 1; s1_arvalid = 1; s0_araddr = 32'h100; s1_araddr = 32'h200;
      m_arready = 1; m_rvalid = 1; s0_rready = 1; s1_rready = 1;
      for (int k = 0; k < 3; k++) begin
         m_rdata = 32'hA5A50000 + k;
         @(negedge clk);
         chk(0, "rr_s0_arready", s0_arready[0], k % 2 == 0);
         chk(0, "rr_s1_arready", s1_arready[0], k % 2 == 1);
         chk(1, "fp_s1_arready", s1_arready[1], 1);
         cyc();
         @(negedge clk);
         chk(0, "rr_m_araddr", m_araddr[0], (k % 2 == 1) ? 32'h200 : 32'h100);
         chk(1, "fp_m_araddr", m_araddr[1], 32'h200);
         cyc();
         @(negedge clk);
         chk(1, "fp_s1_rdata", s1_rdata[1], 32'hA5A50000 + k);
         chk(0, "rr_busy_data", busy[0], 1);
         cyc();
      end
      s1_arvalid = 0;
      @(negedge clk);
      chk(1, "fp_s0_after_drop", s0_arready[1], 1);
      s0_arvalid = 0;
      repeat (4) cyc();
      // requester holds off rready for four cycles while memory data waits
      s0_arvalid = 1; s0_araddr = 32'h300; s0_rready = 0; m_rdata = 32'h12345678;
      cyc(); s0_arvalid = 0;
      cyc();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk(0, "t5_m_rready_low", m_rready[0], 0);
         chk(0, "t5_busy", busy[0], 1);
         cyc();
      end
      s0_rready = 1;
      @(negedge clk);
      chk(0, "t5_m_rready", m_rready[0], 1);
      chk(0, "t5_rdata", s0_rdata[0], 32'h12345678);
      cyc();
      @(negedge clk);
      chk(0, "t5_busy_done", busy[0], 0);
      // asynchronous reset in DATA, then an s1 read carrying SLVERR
      m_rvalid = 0; s1_arvalid = 1; s1_araddr = 32'h400;
      cyc(); s1_arvalid = 0;
      cyc();
      @(negedge clk);
      chk(1, "t6_busy_data", busy[1], 1);
      #2 reset = 0;
      #1;
      chk(0, "t6_async_busy", busy[0], 0);
      chk(1, "t6_async_m_arvalid", m_arvalid[1], 0);
      chk(1, "t6_async_araddr", m_araddr[1], 0);
      chk(1, "t6_async_grant", grant[1], 0);
      cyc(); cyc(); reset = 1;
      s1_arvalid = 1; m_rvalid = 1; m_rresp = 2'b10; s1_rready = 1;
      @(negedge clk);
      chk(0, "t6_s1_arready", s1_arready[0], 1);
      cyc(); s1_arvalid = 0;
      cyc();
      @(negedge clk);
      chk(0, "t6_s1_rresp", s1_rresp[0], 2'b10);
      chk(1, "t6_s1_rvalid", s1_rvalid[1], 1);
      cyc();
      // random traffic checked only by the model
      for (int k = 0; k < 3000; k++) begin
         s0_arvalid = $urandom_range(0, 2) != 0; s1_arvalid = $urandom_range(0, 2) != 0;
         s0_araddr = $urandom; s1_araddr = $urandom;
         s0_arprot = 3'($urandom); s1_arprot = 3'($urandom);
         s0_rready = $urandom_range(0, 1) == 1; s1_rready = $urandom_range(0, 1) == 1;
         m_arready = $urandom_range(0, 1) == 1; m_rvalid = $urandom_range(0, 1) == 1;
         m_rdata = $urandom; m_rresp = 2'($urandom);
         cyc();
      end
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
